ct_ciu_vb_sched: RTL and testbench
==================================

Name: ct_ciu_vb_sched

Overview:
Scheduler for the CIU victim buffer (VB) entry array.
- Allocates free entries to incoming victim writes and drives each entry's create select.
- Round-robin arbitrates entries that hold both address and data onto the single EBIU AXI AW channel, then sequences 4-beat W bursts in AW issue order.
- Frees entries on B response.
- Sits between the L2C/SNB victim sources, the VB entry array and the EBIU write interface.

Parameters:
ENTRY_NUM, 8, number of VB entries (power of 2, max 8)
ID_W, 3, AXI ID width; awid carries the entry index
BEATS, 4, W beats per victim line

Ports:
vb_ctrl_clk  in  1  clock
cpurst_b  in  1  asynchronous reset, active-low
alloc_req  in  1  victim source requests an entry
alloc_gnt  out  1  entry granted this cycle
vb_aw_create_sel  out  ENTRY_NUM  one-hot create select to entries
entry_aw_vld  in  ENTRY_NUM  per-entry valid
entry_aw_en  in  ENTRY_NUM  per-entry AW not yet issued
entry_w_vld  in  ENTRY_NUM  per-entry data present
vb_aw_req_sel  out  ENTRY_NUM  one-hot pulse, AW issued (clears entry aw_en)
vb_w_pop_sel  out  ENTRY_NUM  one-hot pulse, entry freed
awvalid  out  1  AXI AW valid
awready  in  1  AXI AW ready
awid  out  ID_W  issuing entry index
aw_sel  out  ENTRY_NUM  one-hot AW mux select
wvalid  out  1  AXI W valid
wready  in  1  AXI W ready
wlast  out  1  last beat
w_sel  out  ENTRY_NUM  one-hot W data mux select
w_beat  out  2  current beat index
bvalid  in  1  AXI B valid
bid  in  ID_W  B response ID
bready  out  1  constant 1
vb_full  out  1  no free entry
vb_empty  out  1  all entries invalid and no burst pending

Behaviour:
- Reset: alloc_gnt, vb_aw_create_sel, vb_aw_req_sel, vb_w_pop_sel, awvalid, wvalid, wlast, w_beat = 0; awid = 0; aw_sel, w_sel = 0; RR pointer = 0; W order FIFO empty; bready = 1; vb_full = 0; vb_empty = 1. Reset mid-burst discards all state; no recovery.
- Allocation (combinational):
  - free = ~entry_aw_vld.
  - Pick the lowest-index free entry.
  - alloc_gnt = alloc_req & |free; vb_aw_create_sel = one-hot of that entry when granted, else 0.
  - The entry shows valid the next cycle.
  - vb_full = ~|free.
- AW FSM, states IDLE and REQ:
  - IDLE: cand = entry_aw_vld & entry_aw_en & entry_w_vld. If cand is non-zero, pick the first candidate at or after the RR pointer (wrapping), register aw_sel and awid, set awvalid, go to REQ.
  - REQ: awvalid and awid held stable until awready. On handshake:
    - vb_aw_req_sel = aw_sel for exactly that cycle.
    - Push awid into the W order FIFO.
    - RR pointer = winner+1 mod ENTRY_NUM.
    - awvalid deasserts; return to IDLE. Minimum 1 idle cycle between AWs.
  - Back-pressure: no new AW while the W FIFO is full; the FIFO depth is ENTRY_NUM, so this cannot occur in practice.
- W sequencing:
  - wvalid = FIFO non-empty; w_sel = one-hot(FIFO head); w_beat counts 0..BEATS-1 on each wvalid&wready; wlast = (w_beat==BEATS-1).
  - On the last handshake, pop the FIFO and reset w_beat to 0.
  - The next burst may start the following cycle.
  - W for an entry can begin the cycle after its AW handshake (FIFO write then read, 1-cycle latency). W never precedes its AW.
- B:
  - bready = 1.
  - On bvalid, vb_w_pop_sel = one-hot(bid) combinationally, gated by entry_aw_vld[bid].
  - A B response for an invalid entry, or with bid >= ENTRY_NUM, is ignored.
- Simultaneous events:
  - Alloc and pop in the same cycle are independent; the popped entry becomes free the next cycle, so it is never re-granted the same cycle.
  - AW handshake and W last in the same cycle: push and pop the FIFO together; count unchanged.
- vb_empty = ~|entry_aw_vld & FIFO empty & ~awvalid.

Test Plan:
- Reset: assert cpurst_b=0 mid-burst -> all outputs 0, bready=1, vb_empty=1; the next AW starts from entry 0.
- Alloc: entry_aw_vld=8'b0000_0101, alloc_req=1 -> alloc_gnt=1, create_sel=8'b0000_0010. With all entries valid -> alloc_gnt=0, vb_full=1.
- RR AW: entries 1, 3, 6 ready, awready=1 always -> awid order 1,3,6, then 1 again once re-armed; each vb_aw_req_sel pulse is 1 cycle.
- AW stall: awready low for 5 cycles -> awvalid and awid held; the req_sel pulse occurs only on the handshake cycle.
- W ordering: AW for 2 then 5, wready toggling 1/0 -> 4 beats with w_sel=entry 2, wlast on beat 3, then 4 beats for entry 5. w_beat never skips.
- B: bvalid with bid=5 -> vb_w_pop_sel=8'b0010_0000 for 1 cycle. bid=7 with entry 7 invalid -> no pop.

Source files
------------

// File: rtl/ct_ciu_vb_sched.sv
// CIU victim buffer scheduler: entry allocation, round-robin AW issue,
// in-order W burst sequencing and B-driven entry release.
module ct_ciu_vb_sched #(
  parameter int ENTRY_NUM = 8,
  parameter int ID_W      = 3,
  parameter int BEATS     = 4
) (
  input  logic                 vb_ctrl_clk,
  input  logic                 cpurst_b,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [ENTRY_NUM-1:0] vb_aw_create_sel,
  input  logic [ENTRY_NUM-1:0] entry_aw_vld,
  input  logic [ENTRY_NUM-1:0] entry_aw_en,
  input  logic [ENTRY_NUM-1:0] entry_w_vld,
  output logic [ENTRY_NUM-1:0] vb_aw_req_sel,
  output logic [ENTRY_NUM-1:0] vb_w_pop_sel,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [ID_W-1:0]      awid,
  output logic [ENTRY_NUM-1:0] aw_sel,
  output logic                 wvalid,
  input  logic                 wready,
  output logic                 wlast,
  output logic [ENTRY_NUM-1:0] w_sel,
  output logic [1:0]           w_beat,
  input  logic                 bvalid,
  input  logic [ID_W-1:0]      bid,
  output logic                 bready,
  output logic                 vb_full,
  output logic                 vb_empty
);

  localparam int IDX_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  localparam int BID_N = 1 << ID_W;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);
  localparam logic [ENTRY_NUM-1:0] ONE = {{(ENTRY_NUM-1){1'b0}}, 1'b1};
  localparam logic [BID_N-1:0] BID_ONE = {{(BID_N-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0] DEPTH = ENTRY_NUM[IDX_W:0];

  logic [ENTRY_NUM-1:0] free;
  logic                 free_hit;
  logic [IDX_W-1:0]     free_idx;
  logic [ENTRY_NUM-1:0] cand;
  logic                 rr_hit;
  logic [IDX_W-1:0]     rr_idx;
  logic [IDX_W-1:0]     rr_k;
  logic [IDX_W-1:0]     rr_ptr;
  logic [0:0]           aw_state;
  logic [IDX_W-1:0]     aw_idx;
  logic                 aw_hs;
  logic [IDX_W-1:0]     fifo_mem [ENTRY_NUM];
  logic [IDX_W-1:0]     wr_ptr;
  logic [IDX_W-1:0]     rd_ptr;
  logic [IDX_W:0]       fifo_cnt;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [IDX_W-1:0]     w_head;
  logic                 w_hs;
  logic                 w_done;
  logic [BID_N-1:0]     bid_dec;

  assign free = ~entry_aw_vld;

  // descending scan, last hit wins -> lowest free index
  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (free[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign alloc_gnt        = alloc_req & free_hit;
  assign vb_aw_create_sel = alloc_gnt ? (ONE << free_idx) : '0;
  assign vb_full          = ~free_hit;

  assign cand = entry_aw_vld & entry_aw_en & entry_w_vld;

  // smallest offset from rr_ptr wins; index arithmetic wraps
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    rr_k   = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      rr_k = rr_ptr + IDX_W'(i);
      if (cand[rr_k]) begin
        rr_hit = 1'b1;
        rr_idx = rr_k;
      end
    end
  end

  assign awvalid       = (aw_state == REQ);
  assign aw_hs         = awvalid & awready;
  assign awid          = ID_W'(aw_idx);
  assign vb_aw_req_sel = aw_hs ? aw_sel : '0;

  always_ff @(posedge vb_ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      aw_state <= IDLE;
      aw_idx   <= '0;
      aw_sel   <= '0;
      rr_ptr   <= '0;
    end else begin
      unique case (aw_state)
        IDLE: begin
          if (rr_hit && !fifo_full) begin
            aw_state <= REQ;
            aw_idx   <= rr_idx;
            aw_sel   <= ONE << rr_idx;
          end
        end
        REQ: begin
          if (awready) begin
            aw_state <= IDLE;
            rr_ptr   <= aw_idx + IDX_W'(1);
          end
        end
      endcase
    end
  end

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH);
  assign w_head     = fifo_mem[rd_ptr];
  assign wvalid     = ~fifo_empty;
  assign w_sel      = wvalid ? (ONE << w_head) : '0;
  assign wlast      = (w_beat == LAST_BEAT);
  assign w_hs       = wvalid & wready;
  assign w_done     = w_hs & wlast;

  always_ff @(posedge vb_ctrl_clk) begin
    if (aw_hs) fifo_mem[wr_ptr] <= aw_idx;
  end

  always_ff @(posedge vb_ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      w_beat   <= '0;
    end else begin
      if (aw_hs) wr_ptr <= wr_ptr + IDX_W'(1);
      if (w_done) rd_ptr <= rd_ptr + IDX_W'(1);
      if (aw_hs && !w_done)
        fifo_cnt <= fifo_cnt + (IDX_W+1)'(1);
      else if (!aw_hs && w_done)
        fifo_cnt <= fifo_cnt - (IDX_W+1)'(1);
      if (w_hs) w_beat <= wlast ? 2'd0 : w_beat + 2'd1;
    end
  end

  // ids beyond the entry range decode outside the kept slice
  assign bid_dec      = BID_ONE << bid;
  assign vb_w_pop_sel = bvalid ? (bid_dec[ENTRY_NUM-1:0] & entry_aw_vld) : '0;
  assign bready       = 1'b1;

  assign vb_empty = ~|entry_aw_vld & fifo_empty & ~awvalid;

endmodule

// File: tb/tb_ct_ciu_vb_sched.sv
// Directed bench for ct_ciu_vb_sched: alloc, RR AW issue, AW stall,
// W burst ordering, B release and mid-burst reset.
module tb_ct_ciu_vb_sched;

  localparam int EN = 8;
  localparam int IW = 3;
  localparam int BEATS = 4;

  logic          clk = 1'b0;
  logic          cpurst_b;
  logic          alloc_req;
  logic          alloc_gnt;
  logic [EN-1:0] vb_aw_create_sel;
  logic [EN-1:0] entry_aw_vld;
  logic [EN-1:0] entry_aw_en;
  logic [EN-1:0] entry_w_vld;
  logic [EN-1:0] vb_aw_req_sel;
  logic [EN-1:0] vb_w_pop_sel;
  logic          awvalid;
  logic          awready;
  logic [IW-1:0] awid;
  logic [EN-1:0] aw_sel;
  logic          wvalid;
  logic          wready;
  logic          wlast;
  logic [EN-1:0] w_sel;
  logic [1:0]    w_beat;
  logic          bvalid;
  logic [IW-1:0] bid;
  logic          bready;
  logic          vb_full;
  logic          vb_empty;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ct_ciu_vb_sched #(.ENTRY_NUM(EN), .ID_W(IW), .BEATS(BEATS)) dut (
    .vb_ctrl_clk      (clk),
    .cpurst_b         (cpurst_b),
    .alloc_req        (alloc_req),
    .alloc_gnt        (alloc_gnt),
    .vb_aw_create_sel (vb_aw_create_sel),
    .entry_aw_vld     (entry_aw_vld),
    .entry_aw_en      (entry_aw_en),
    .entry_w_vld      (entry_w_vld),
    .vb_aw_req_sel    (vb_aw_req_sel),
    .vb_w_pop_sel     (vb_w_pop_sel),
    .awvalid          (awvalid),
    .awready          (awready),
    .awid             (awid),
    .aw_sel           (aw_sel),
    .wvalid           (wvalid),
    .wready           (wready),
    .wlast            (wlast),
    .w_sel            (w_sel),
    .w_beat           (w_beat),
    .bvalid           (bvalid),
    .bid              (bid),
    .bready           (bready),
    .vb_full          (vb_full),
    .vb_empty         (vb_empty)
  );

  function automatic logic [EN-1:0] oh(input int e);
    oh = 8'd1 << e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [EN-1:0] m);
    entry_aw_vld = m;
    entry_aw_en  = m;
    entry_w_vld  = m;
  endtask

  // wait for AW of entry e, stall awready for 'stall' cycles, then handshake
  task automatic aw_issue(input int e, input int stall);
    int n = 0;
    awready = (stall == 0);
    while (!awvalid && n < 20) begin
      tick();
      n++;
    end
    chk("aw_start", awvalid, 1);
    for (int i = 0; i < stall; i++) begin
      chk("aw_hold_id", awid, e);
      chk("aw_nopulse", vb_aw_req_sel, 0);
      tick();
      chk("aw_hold_vld", awvalid, 1);
    end
    awready = 1'b1;
    #1;
    chk("awid", awid, e);
    chk("aw_sel", aw_sel, oh(e));
    chk("req_sel", vb_aw_req_sel, oh(e));
    tick();
    entry_aw_en[e] = 1'b0;
    chk("req_pulse_end", vb_aw_req_sel, 0);
    chk("aw_drop", awvalid, 0);
  endtask

  // drain one 4-beat burst for entry e; tog toggles wready 1/0
  task automatic w_burst(input int e, input bit tog);
    int b = 0;
    int n = 0;
    bit ph = 1'b1;
    while (b < BEATS && n < 40) begin
      wready = tog ? ph : 1'b1;
      ph = ~ph;
      #1;
      if (wvalid && wready) begin
        chk("w_sel", w_sel, oh(e));
        chk("w_beat", w_beat, b);
        chk("wlast", wlast, (b == BEATS - 1));
        b++;
      end else if (wvalid) begin
        chk("w_beat_hold", w_beat, b);
      end
      tick();
      n++;
    end
    chk("w_beats_done", b, BEATS);
    wready = 1'b0;
  endtask

  initial begin
    cpurst_b  = 1'b0;
    alloc_req = 1'b0;
    arm(8'h00);
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bid     = '0;
    #2;
    chk("rst_gnt", alloc_gnt, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 1);
    chk("rst_empty", vb_empty, 1);
    chk("rst_full", vb_full, 0);
    tick();
    tick();
    cpurst_b = 1'b1;

    // allocation
    alloc_req = 1'b1;
    entry_aw_vld = 8'b0000_0101;
    #1;
    chk("alloc_gnt", alloc_gnt, 1);
    chk("alloc_sel", vb_aw_create_sel, 8'b0000_0010);
    chk("alloc_notfull", vb_full, 0);
    chk("alloc_notempty", vb_empty, 0);
    entry_aw_vld = 8'hff;
    #1;
    chk("full_gnt", alloc_gnt, 0);
    chk("full_sel", vb_aw_create_sel, 0);
    chk("full_flag", vb_full, 1);
    alloc_req = 1'b0;
    tick();

    // round-robin AW: 1, 3, 6, then 1 again after re-arm
    arm(8'b0100_1010);
    aw_issue(1, 0);
    aw_issue(3, 0);
    aw_issue(6, 0);
    entry_aw_en[1] = 1'b1;
    aw_issue(1, 0);
    w_burst(1, 0);
    w_burst(3, 0);
    w_burst(6, 0);
    w_burst(1, 0);
    chk("w_idle_rr", wvalid, 0);

    // AW stall: entry 3 re-armed, awready low 5 cycles
    entry_aw_en[3] = 1'b1;
    aw_issue(3, 5);
    w_burst(3, 0);

    // W ordering: AW 2 then 5, wready toggling
    arm(8'h04);
    aw_issue(2, 0);
    chk("w_follow_aw", wvalid, 1);
    chk("w_follow_sel", w_sel, 8'h04);
    chk("w_follow_beat", w_beat, 0);
    entry_aw_vld[5] = 1'b1;
    entry_aw_en[5]  = 1'b1;
    entry_w_vld[5]  = 1'b1;
    aw_issue(5, 0);
    w_burst(2, 1);
    w_burst(5, 1);
    chk("w_idle_order", wvalid, 0);

    // B release
    entry_aw_en  = 8'h00;
    entry_aw_vld = 8'h24;
    bvalid = 1'b1;
    bid    = 3'd5;
    #1;
    chk("b_pop5", vb_w_pop_sel, 8'b0010_0000);
    tick();
    bvalid = 1'b0;
    #1;
    chk("b_pop_end", vb_w_pop_sel, 0);
    bvalid = 1'b1;
    bid    = 3'd7;
    #1;
    chk("b_pop_invalid", vb_w_pop_sel, 0);
    bid = 3'd2;
    #1;
    chk("b_pop2", vb_w_pop_sel, 8'b0000_0100);
    bvalid = 1'b0;
    arm(8'h00);
    #1;
    chk("empty_after", vb_empty, 1);
    tick();

    // reset mid-burst, then AW restarts at entry 0
    arm(8'h10);
    aw_issue(4, 0);
    wready = 1'b1;
    tick();
    chk("pre_rst_beat", w_beat, 1);
    arm(8'h00);
    wready = 1'b0;
    cpurst_b = 1'b0;
    #1;
    chk("mrst_awvalid", awvalid, 0);
    chk("mrst_wvalid", wvalid, 0);
    chk("mrst_wlast", wlast, 0);
    chk("mrst_beat", w_beat, 0);
    chk("mrst_wsel", w_sel, 0);
    chk("mrst_awid", awid, 0);
    chk("mrst_awsel", aw_sel, 0);
    chk("mrst_bready", bready, 1);
    chk("mrst_empty", vb_empty, 1);
    chk("mrst_full", vb_full, 0);
    #2;
    cpurst_b = 1'b1;
    arm(8'b0010_0001);
    aw_issue(0, 0);
    aw_issue(5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
